// File: rtl/seq_divider.sv
// seq_divider: multi-cycle 8-bit unsigned restoring divider.
// It produces one quotient bit per clock (MSB first) using a 9-bit partial
// remainder, and a start/done handshake.
//
// Handshake: a request is accepted on any rising edge where start=1 and the
// divider is not busy (state IDLE or DONE). busy is high while iterating.
// done is a one-cycle pulse, and quotient/remainder/div_by_zero are valid in
// that cycle. The results are then held until the next result is written.
//
// Optional feature macro: DIV_ZERO_CHECK_EN. When it is defined, a zero
// divisor skips the iterations and sets div_by_zero.
module seq_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  // Dividend shift register. Quotient bits shift in at the LSB, so after
  // 8 iterations this register holds the quotient.
  logic [7:0]  dvd_q, dvd_d;
  logic [7:0]  dvs_q, dvs_d;
  logic [8:0]  r_q, r_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  quo_q, quo_d;
  logic [7:0]  rem_q, rem_d;

  logic [8:0]  r_shift;
  logic [9:0]  trial;
  logic        no_borrow;
  logic [8:0]  r_next;
  // After a restore, R is always below the divisor. Its MSB is therefore
  // zero whenever it is shifted, so that bit is never read.
  logic        r_msb_unused;

  assign r_msb_unused = r_q[8];

  // One restoring iteration: shift in the next dividend bit, then try to
  // subtract the divisor as R + ~{0,divisor} + 1.
  always_comb begin
    r_shift   = {r_q[7:0], dvd_q[7]};
    trial     = {1'b0, r_shift} + {2'b01, ~dvs_q} + 10'd1;
    no_borrow = trial[9];
    r_next    = no_borrow ? trial[8:0] : r_shift;
  end

`ifdef DIV_ZERO_CHECK_EN
  logic dbz_q, dbz_d;
`endif

  // Next-state logic and datapath control.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef DIV_ZERO_CHECK_EN
    dbz_d   = dbz_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          r_d     = 9'd0;
          cnt_d   = 3'd0;
          state_d = S_RUN;
`ifdef DIV_ZERO_CHECK_EN
          dbz_d   = 1'b0;
          if (divisor == 8'd0) begin
            state_d = S_DONE;
            quo_d   = 8'hFF;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end
`endif
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        r_d   = r_next;
        dvd_d = {dvd_q[6:0], no_borrow};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
          quo_d   = {dvd_q[6:0], no_borrow};
          rem_d   = r_next[7:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= 8'd0;
      dvs_q   <= 8'd0;
      r_q     <= 9'd0;
      cnt_q   <= 3'd0;
      quo_q   <= 8'd0;
      rem_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  // Divide-by-zero flag, held with the results.
  always_ff @(posedge clk) begin
    if (rst) dbz_q <= 1'b0;
    else     dbz_q <= dbz_d;
  end
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider. Expected values are hand-computed.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

`ifdef DIV_ZERO_CHECK_EN
  localparam int ZERO_LAT = 1;
  localparam int ZERO_DBZ = 1;
`else
  localparam int ZERO_LAT = 9;
  localparam int ZERO_DBZ = 0;
`endif

  seq_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .state_dbg   (state_dbg)
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  // Advance one cycle. Inputs and outputs change/are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Driver: one-cycle start pulse, then a bounded wait for done.
  // lat counts cycles from the start cycle to the done cycle.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, output int lat);
    start = 1'b1; dividend = a; divisor = b;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 30) begin
      tick();
      lat++;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL timeout: observed no done expected done within 30 cycles");
    end
  endtask

  task automatic div_case(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input int exp_lat, input logic [7:0] eq, input logic [7:0] er,
                          input logic edbz);
    int lat;
    run_div(a, b, lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, edbz);
  endtask

  initial begin
    int n_done;
    int done_at;
    int lat;
    logic [7:0] q_at, r_at;
    rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    tick(); tick();
    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_state", state_dbg, 0);
    rst = 1'b0;
    tick();

    // 100 / 7: busy in cycles 1-8, done in cycle 9
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("b100_busy", busy, 1);
      chk("b100_nodone", done, 0);
      tick();
    end
    chk("b100_done", done, 1);
    chk("b100_busy_lo", busy, 0);
    chk("b100_q", quotient, 14);
    chk("b100_r", remainder, 2);
    tick();
    chk("b100_pulse", done, 0);
    chk("b100_hold_q", quotient, 14);
    chk("b100_hold_r", remainder, 2);
    tick();

    // Back-to-back: 255 / 1, then 5 / 10 captured in the DONE cycle
    start = 1'b1; dividend = 8'd255; divisor = 8'd1;
    tick();
    dividend = 8'd5; divisor = 8'd10;
    for (int i = 0; i < 8; i++) tick();
    chk("bb1_done", done, 1);
    chk("bb1_q", quotient, 255);
    chk("bb1_r", remainder, 0);
    tick();
    start = 1'b0;
    chk("bb2_busy", busy, 1);
    for (int i = 0; i < 8; i++) tick();
    chk("bb2_done", done, 1);
    chk("bb2_q", quotient, 0);
    chk("bb2_r", remainder, 5);
    tick();

    // Divide by zero
    div_case("z200", 8'd200, 8'd0, ZERO_LAT, 8'hFF, 8'd200, ZERO_DBZ[0]);
    tick();

    // A start pulse during busy is ignored
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    tick();
    start = 1'b0;
    n_done = 0; done_at = 0; q_at = 8'd0; r_at = 8'd0;
    for (int c = 5; c <= 14; c++) begin
      if (done) begin
        n_done++;
        done_at = c;
        q_at = quotient;
        r_at = remainder;
      end
      tick();
    end
    chk("ign_ndone", n_done, 1);
    chk("ign_cycle", done_at, 9);
    chk("ign_q", q_at, 14);
    chk("ign_r", r_at, 2);

    // Reset mid-run at cycle 5
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_q", quotient, 0);
    chk("mr_r", remainder, 0);
    chk("mr_dbz", div_by_zero, 0);
    chk("mr_state", state_dbg, 0);
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) n_done++;
      tick();
    end
    chk("mr_nodone", n_done, 0);
    div_case("d9_3", 8'd9, 8'd3, 9, 8'd3, 8'd0, 1'b0);
    tick();

    // Borrow at the 9-bit boundary
    div_case("ff_ff", 8'hFF, 8'hFF, 9, 8'd1, 8'd0, 1'b0);
    tick();
    div_case("80_81", 8'h80, 8'h81, 9, 8'd0, 8'd128, 1'b0);
    tick();

    // Zero divide again, then a normal division clears div_by_zero
    run_div(8'd17, 8'd0, lat);
    chk("z17_dbz", div_by_zero, ZERO_DBZ);
    chk("z17_r", remainder, 17);
    div_case("d200_9", 8'd200, 8'd9, 9, 8'd22, 8'd2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #50000;
    $display("FAIL watchdog: observed no completion expected finish before 50000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
